// File: rtl/set_multi_if.sv
// Host-side bundle for set_multi: start request, three packed circles, mode in;
// busy/valid/candidate out. The host drives master, the counter is the slave.
interface set_multi_if #(
    parameter int CW    = 4,
    parameter int RW    = 4,
    parameter int CNT_W = 8
);
    logic               en;
    logic [6*CW-1:0]    central;
    logic [3*RW-1:0]    radius;
    logic [2:0]         mode;
    logic               busy;
    logic               valid;
    logic [CNT_W-1:0]   candidate;

    modport master (
        output en, central, radius, mode,
        input  busy, valid, candidate
    );

    modport slave (
        input  en, central, radius, mode,
        output busy, valid, candidate
    );
endinterface

// File: rtl/set_multi.sv
// Counts GRID x GRID lattice points satisfying a set operation over three circles.
// One point per cycle, result 65 edges after capture at GRID=8; en is dropped while busy.
module set_multi #(
    parameter int GRID  = 8,
    parameter int CW    = 4,
    parameter int RW    = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    set_multi_if.slave bus
);
    localparam int DW = (2*CW+3 > 2*RW) ? 2*CW+3 : 2*RW;
    localparam logic [CW-1:0] LAST = CW'(GRID);
    localparam logic [CW-1:0] FIRST = CW'(1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             r_state;
    logic [6*CW-1:0]    r_central;
    logic [3*RW-1:0]    r_radius;
    logic [2:0]         r_mode;
    logic [CW-1:0]      r_x;
    logic [CW-1:0]      r_y;
    logic               r_drain;
    logic               r_hit;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_candidate;
    logic               r_valid;

    logic [2:0]         w_in;
    logic               w_hit;

    // Index 0 is circle A, 1 is B, 2 is C.
    for (genvar i = 0; i < 3; i++) begin : g_circle
        logic [CW-1:0]      w_cx;
        logic [CW-1:0]      w_cy;
        logic [RW-1:0]      w_r;
        logic signed [CW:0] w_dx;
        logic signed [CW:0] w_dy;
        logic [CW:0]        w_ax;
        logic [CW:0]        w_ay;
        logic [DW-1:0]      w_ex;
        logic [DW-1:0]      w_ey;
        logic [DW-1:0]      w_er;
        logic [DW-1:0]      w_d2;
        logic [DW-1:0]      w_r2;

        assign w_cx = r_central[(6-2*i)*CW-1 -: CW];
        assign w_cy = r_central[(5-2*i)*CW-1 -: CW];
        assign w_r  = r_radius[(3-i)*RW-1 -: RW];

        assign w_dx = $signed({1'b0, w_cx}) - $signed({1'b0, r_x});
        assign w_dy = $signed({1'b0, w_cy}) - $signed({1'b0, r_y});
        assign w_ax = w_dx[CW] ? $unsigned(-w_dx) : $unsigned(w_dx);
        assign w_ay = w_dy[CW] ? $unsigned(-w_dy) : $unsigned(w_dy);

        assign w_ex = {{(DW-CW-1){1'b0}}, w_ax};
        assign w_ey = {{(DW-CW-1){1'b0}}, w_ay};
        assign w_er = {{(DW-RW){1'b0}}, w_r};

        assign w_d2 = (w_ex * w_ex) + (w_ey * w_ey);
        assign w_r2 = w_er * w_er;
        assign w_in[i] = (w_d2 <= w_r2);
    end

    always_comb begin
        w_hit = 1'b0;
        case (r_mode)
            3'd0:    w_hit = w_in[0];
            3'd1:    w_hit = w_in[0] & w_in[1];
            3'd2:    w_hit = w_in[0] ^ w_in[1];
            3'd3:    w_hit = w_in[0] | w_in[1];
            3'd4:    w_hit = (w_in == 3'b011) | (w_in == 3'b101) | (w_in == 3'b110);
            3'd5:    w_hit = &w_in;
            default: w_hit = 1'b0;
        endcase
    end

    // The membership bit is registered before accumulation, so the scan needs
    // one drain cycle after the last point before the result can be published.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_central   <= '0;
            r_radius    <= '0;
            r_mode      <= '0;
            r_x         <= FIRST;
            r_y         <= FIRST;
            r_drain     <= 1'b0;
            r_hit       <= 1'b0;
            r_cnt       <= '0;
            r_candidate <= '0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (bus.en) begin
                        r_central <= bus.central;
                        r_radius  <= bus.radius;
                        r_mode    <= bus.mode;
                        r_x       <= FIRST;
                        r_y       <= FIRST;
                        r_drain   <= 1'b0;
                        r_hit     <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    r_cnt <= r_cnt + CNT_W'(r_hit);
                    if (r_drain) begin
                        r_candidate <= r_cnt + CNT_W'(r_hit);
                        r_valid     <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_hit <= w_hit;
                        if (r_x == LAST) begin
                            r_x <= FIRST;
                            if (r_y == LAST) begin
                                r_drain <= 1'b1;
                            end else begin
                                r_y <= r_y + 1'b1;
                            end
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.valid     = r_valid;
    assign bus.candidate = r_candidate;
endmodule

// File: tb/tb_set_multi.sv
// Directed jobs with a scoreboard: the driver queues expected counts,
// a negedge monitor pops and checks whenever valid is presented.
module tb_set_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;

    set_multi_if #(.CW(4), .RW(4), .CNT_W(8)) bus();

    set_multi #(.GRID(8), .CW(4), .RW(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] cand;
        int         cap;
        string      name;
    } exp_t;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    idle_req = 0;
    int    idle_seen = 0;
    int    tmo_req = 0;
    int    tmo_seen = 0;
    string tmo_name = "";
    logic  prev_valid = 1'b0;
    int    busy_chk_at = -1;

    function automatic logic [23:0] cen(input logic [3:0] xa, ya, xb, yb, xc, yc);
        return {xa, ya, xb, yb, xc, yc};
    endfunction

    function automatic logic [11:0] rad(input logic [3:0] ra, rb, rc);
        return {ra, rb, rc};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: sole owner of the check counters.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (idle_seen != idle_req) begin
                chk("idle_busy", int'(bus.busy), 0);
                chk("idle_valid", int'(bus.valid), 0);
                chk("idle_candidate", int'(bus.candidate), 0);
                idle_seen++;
            end
            while (tmo_seen != tmo_req) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout %s: busy or result still outstanding, expected completion within bound", tmo_name);
                tmo_seen++;
            end
            if (bus.valid) begin
                chk("valid_pulse_width", int'(prev_valid), 0);
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid with candidate %0d, expected no valid", bus.candidate);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_candidate"}, int'(bus.candidate), int'(e.cand));
                    chk({e.name, "_latency"}, cyc - e.cap, 65);
                    chk({e.name, "_busy_at_valid"}, int'(bus.busy), 1);
                    busy_chk_at = cyc + 1;
                end
            end
            if (cyc == busy_chk_at) begin
                chk("busy_release", int'(bus.busy), 0);
            end
            prev_valid = bus.valid;
        end
    end

    task automatic start_job(input string name, input logic [23:0] c, input logic [11:0] r,
                             input logic [2:0] m, input logic [7:0] exp_cnt, input bit push);
        exp_t e;
        int   t;
        t = 0;
        while (bus.busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) begin
            tmo_name = name;
            tmo_req++;
        end
        bus.central = c;
        bus.radius  = r;
        bus.mode    = m;
        bus.en      = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        if (push) begin
            e.cand = exp_cnt;
            e.cap  = cyc;
            e.name = name;
            q.push_back(e);
        end
    endtask

    initial begin
        int t;
        bus.en      = 1'b0;
        bus.central = '0;
        bus.radius  = '0;
        bus.mode    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_req++;
        repeat (2) @(negedge clk);

        start_job("circleA",  cen(4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0), rad(4'd2, 4'd0, 4'd0), 3'd0, 8'd13, 1'b1);
        start_job("and_ab",   cen(4'd4, 4'd4, 4'd5, 4'd4, 4'd0, 4'd0), rad(4'd2, 4'd2, 4'd0), 3'd1, 8'd8,  1'b1);
        start_job("xor_ab",   cen(4'd4, 4'd4, 4'd5, 4'd4, 4'd0, 4'd0), rad(4'd2, 4'd2, 4'd0), 3'd2, 8'd10, 1'b1);
        start_job("or_ab",    cen(4'd4, 4'd4, 4'd5, 4'd4, 4'd0, 4'd0), rad(4'd2, 4'd2, 4'd0), 3'd3, 8'd18, 1'b1);
        start_job("a_only",   cen(4'd4, 4'd4, 4'd5, 4'd4, 4'd0, 4'd0), rad(4'd2, 4'd2, 4'd0), 3'd0, 8'd13, 1'b1);
        start_job("and_abc",  cen(4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2), rad(4'd1, 4'd1, 4'd1), 3'd5, 8'd5,  1'b1);
        start_job("two_same", cen(4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2), rad(4'd1, 4'd1, 4'd1), 3'd4, 8'd0,  1'b1);
        start_job("two_offc", cen(4'd2, 4'd2, 4'd2, 4'd2, 4'd7, 4'd7), rad(4'd1, 4'd1, 4'd1), 3'd4, 8'd5,  1'b1);
        start_job("corner",   cen(4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0), rad(4'd3, 4'd0, 4'd0), 3'd0, 8'd11, 1'b1);
        start_job("full",     cen(4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0), rad(4'd15, 4'd0, 4'd0), 3'd0, 8'd64, 1'b1);
        start_job("offgrid",  cen(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0), rad(4'd0, 4'd0, 4'd0), 3'd0, 8'd0,  1'b1);
        start_job("mode6",    cen(4'd4, 4'd4, 4'd5, 4'd4, 4'd0, 4'd0), rad(4'd2, 4'd2, 4'd0), 3'd6, 8'd0,  1'b1);
        start_job("mode7",    cen(4'd4, 4'd4, 4'd5, 4'd4, 4'd4, 4'd4), rad(4'd2, 4'd2, 4'd2), 3'd7, 8'd0,  1'b1);

        // A second en during the scan, with different inputs, must be dropped.
        start_job("mid_en",   cen(4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0), rad(4'd2, 4'd0, 4'd0), 3'd0, 8'd13, 1'b1);
        repeat (9) @(negedge clk);
        bus.central = cen(4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
        bus.radius  = rad(4'd15, 4'd15, 4'd15);
        bus.mode    = 3'd3;
        bus.en      = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;

        start_job("mid_cen",  cen(4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0), rad(4'd3, 4'd0, 4'd0), 3'd0, 8'd11, 1'b1);
        repeat (20) @(negedge clk);
        bus.central = cen(4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4);
        bus.radius  = rad(4'd15, 4'd15, 4'd15);

        // Abort a scan with reset: no result, outputs back to reset values.
        start_job("abort",    cen(4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0), rad(4'd15, 4'd0, 4'd0), 3'd0, 8'd64, 1'b0);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_req++;
        repeat (80) @(negedge clk);

        start_job("post_rst", cen(4'd4, 4'd4, 4'd5, 4'd4, 4'd0, 4'd0), rad(4'd2, 4'd2, 4'd0), 3'd3, 8'd18, 1'b1);

        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            tmo_name = "drain";
            tmo_req++;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/set_multi.md
# set_multi

Parametrised grid point-set counter, the next generation of the two-circle set counter. It accepts up to three circles (centres and radii) on a GRID×GRID integer lattice with a set-operation mode. It scans every lattice point once with all three circles tested in parallel, then returns a single count. It sits behind the same en/busy/valid/candidate host handshake, so the host protocol is unchanged.

## Interface
- GRID, 8: lattice size; points are (x,y) with x,y in 1..GRID
- CW, 4: coordinate width per axis; 2^CW > GRID
- RW, 4: radius width
- CNT_W, 8: candidate width; 2^CNT_W > GRID*GRID
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- en  in  1  start request, sampled only while busy=0
- central  in  6*CW  {xA,yA,xB,yB,xC,yC}, xA in MSBs
- radius  in  3*RW  {rA,rB,rC}, rA in MSBs
- mode  in  3  set-operation select
- busy  out  1  1 from capture until the result cycle ends
- valid  out  1  one-cycle result strobe
- candidate  out  CNT_W  result count

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: busy=0. If en=1 at an edge, register central, radius and mode, clear the three-bit-membership counter, set x=y=1, and go to SCAN. Inputs are ignored at all other times.
- SCAN: each cycle, evaluate point (x,y) against all three circles.
  - Membership: a = (xA-x)²+(yA-y)² <= rA². b and c are computed the same way.
  - Differences are signed CW+1 bits. Squares and sums are unsigned, wide enough that they never wrap: sum 2*CW+3 bits, compared against rA² zero-extended.
  - The point is counted if f(a,b,c)=1 for the captured mode.
  - The scan advances x first: x=GRID wraps to 1 and increments y. After (GRID,GRID) the block goes to DONE.
- Modes:
  - 0: a
  - 1: a&b
  - 2: a^b
  - 3: a|b
  - 4: exactly two of {a,b,c}
  - 5: a&b&c
  - 6 and 7: reserved; count is forced to 0 and valid still fires.
- DONE: valid=1 and candidate=final count for exactly one cycle; busy=1. Next state is IDLE.
- candidate holds its value after valid falls, until the next DONE.
- Centres may lie off-grid (0 or >GRID); only lattice points inside the grid count. A radius of 0 counts only the centre, and only if it is on-grid.
- Changes to central, radius or mode during SCAN or DONE have no effect on the result in progress.
- en asserted while busy=1 is dropped, not queued.

## Timing
- Reset: state=IDLE, busy=0, valid=0, candidate=0, counter=0, x=y=1.
- Reset during SCAN or DONE aborts the job: no valid pulse, all outputs take their reset values on the next edge.
- busy is decoded from the state register and is glitch-free. valid and candidate are registered.
- Capture edge E0 (en=1, busy=0):
  - busy=1 from E0 onward.
  - Point k (k=1..GRID²) is evaluated in the cycle after edge E0+k-1.
  - valid=1 in the cycle after edge E0+GRID²+1.
  - busy=0 and a new en is accepted at edge E0+GRID²+2.
- With GRID=8: en-to-valid is 65 edges, and the request-to-request period is 66 cycles.
- Throughput is one point per cycle; there are no stalls.
- en=1 in the first IDLE cycle after DONE is accepted; back-to-back jobs are legal.

## Test plan
- GRID=8, A=(4,4), rA=2, mode 0 -> candidate=13. valid is high exactly one cycle, 65 edges after capture. busy=0 on the next edge.
- A=(4,4), rA=2, B=(5,4), rB=2, run four jobs in modes 1/2/3 and mode 0 -> 8, 10, 18, 13.
- A=B=C=(2,2), all radii 1:
  - mode 5 -> 5, mode 4 -> 0.
  - Change C to (7,7) r=1, mode 4 -> 5.
- Clipping and extremes:
  - A=(1,1), rA=3, mode 0 -> 11.
  - A=(4,4), rA=15, mode 0 -> 64.
  - A=(0,0), rA=0 -> 0.
  - mode 6 -> 0 with valid asserted.
- Handshake and reset:
  - Pulse en with new inputs at cycle 10 of a scan -> ignored; result matches the original inputs.
  - Change central mid-scan -> no effect.
  - Assert rst at cycle 30 of a scan -> no valid, candidate=0, busy=0. The next job completes normally.
